oc3_popcount_ctrl: RTL and testbench
====================================

Name: oc3_popcount_ctrl

Overview:
- Sequential controller that computes the population count of a W-bit word by time-multiplexing one external 3-input ones-counter (OC_3 family: inputs a/b/c, 2-bit result {y1,y0}).
- Each cycle it presents 3 bits to the counter, reads back the 2-bit partial sum and accumulates it.
- Sits between a requester (start/done handshake) and any OC_3 variant: transistor-level, gate-level or assign-level.

Parameters:
- W, 12, input word width; W >= 1.
- G, ceil(W/3), number of 3-bit groups (derived; not overridable).
- CW, $clog2(W+1), width of the count result (derived).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- din  input  W  word to count; captured on the accepted start edge.
- oc_a  output  1  to OC_3 input a (group bit 2).
- oc_b  output  1  to OC_3 input b (group bit 1).
- oc_c  output  1  to OC_3 input c (group bit 0).
- oc_y0  input  1  OC_3 result LSB; combinational from oc_a/b/c within the same cycle.
- oc_y1  input  1  OC_3 result MSB.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when count is valid.
- count  output  CW  popcount result; holds until the next accepted start.

Behaviour:
- Reset (async, active-high): state=IDLE. Shift register, group counter and count go to 0. busy=0, done=0, oc_a/b/c=0. Reset takes effect immediately, including mid-RUN; the aborted operation is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - oc_a/b/c=0.
  - On a clk edge with start=1: load the shift register with din zero-extended to 3*G bits, clear count, clear the group counter, go to RUN.
- RUN:
  - oc_a/b/c = shift[2], shift[1], shift[0] (combinational from the register).
  - At each edge: count <= count + {oc_y1,oc_y0}; shift <= shift >> 3; group counter +1.
  - When the group counter equals G-1 at the edge, go to DONE.
  - start is ignored.
- DONE:
  - done=1 for exactly one cycle; busy=0; oc_a/b/c=0; count holds the final value.
  - start is ignored in this cycle.
  - Next edge goes to IDLE.
- Latency: start accepted at edge k; RUN spans edges k+1..k+G; done is high during the cycle following edge k+G.
  - Back-to-back operation: a new start is accepted no earlier than edge k+G+2.
- Width rules:
  - Accumulation is unsigned CW bits; it cannot overflow because the maximum is W.
  - Padding bits (3*G-W of them) are 0 and contribute nothing.
- count changes only on accepted start (cleared) and during RUN. It is stable in DONE and IDLE.
- The controller trusts the OC_3 result. No checking of oc_y values; X/Z on oc_y propagates into count.
- din is sampled only on the start edge; later changes to din have no effect.

Test Plan:
- Reset: rst=1 with clk idle -> busy=0, done=0, count=0, oc_a/b/c=0 without waiting for a clock edge.
- W=12, din=12'hFFF, start for 1 cycle -> busy high for 4 cycles; {oc_a,oc_b,oc_c}=3'b111 each RUN cycle; done single pulse; count=12; count still 12 three cycles later.
- W=12, din=12'b101_100_011_001 -> per-cycle {oc_a,oc_b,oc_c}= 001, 011, 100, 101; count after each edge = 1, 3, 4, 6; final count=6; din=12'h000 -> count=0, done still pulses after 4 RUN cycles.
- Handshake: pulse start again while busy=1 and in the done cycle -> ignored; count=6 unchanged; the next start in IDLE with din=12'h001 -> count=1.
- Reset mid-operation: din=12'hFFF, assert rst asynchronously after the 2nd RUN edge -> immediate busy=0, count=0, no done pulse; after release, start with din=12'h0F0 -> count=4.
- Padding, W=10: din=10'h3FF -> G=4 RUN cycles; last group drives {oc_a,oc_b,oc_c}=3'b001; count=10.

Source files
------------

// File: rtl/oc3_popcount_ctrl.sv
// Popcount of a W-bit word using one external 3-input ones-counter, one group per cycle.
// Ports: clk, rst, start/din in, oc_a/b/c out, oc_y0/y1 in, busy/done/count out.
module oc3_popcount_ctrl #(
  parameter int W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [W-1:0]             din,
  output logic                     oc_a,
  output logic                     oc_b,
  output logic                     oc_c,
  input  logic                     oc_y0,
  input  logic                     oc_y1,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int G   = (W + 2) / 3;
  localparam int CW  = $clog2(W + 1);
  localparam int SW  = 3 * G;
  localparam int GCW = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SW-1:0]   shift;
  logic [GCW-1:0]  grp;
  logic            last;
  logic [CW-1:0]   part;

  assign last = (grp == GCW'(G - 1));
  // partial sum never exceeds W, so narrowing is safe when CW < 2
  assign part = CW'({oc_y1, oc_y0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    oc_a = 1'b0;
    oc_b = 1'b0;
    oc_c = 1'b0;
    unique case (state)
      RUN: begin
        busy = 1'b1;
        oc_a = shift[2];
        oc_b = shift[1];
        oc_c = shift[0];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      grp   <= '0;
      count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            shift <= SW'(din);
            grp   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          count <= count + part;
          shift <= shift >> 3;
          grp   <= grp + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oc3_popcount_ctrl.sv
// Self-checking bench for oc3_popcount_ctrl (W=12 and W=10 instances).
// Behavioural ones-counters feed each instance; the reference is a plain popcount.
module tb_oc3_popcount_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start12 = 1'b0;
  logic [11:0] din12 = '0;
  logic        a12, b12, c12, y0_12, y1_12;
  logic        busy12, done12;
  logic [3:0]  count12;

  logic        start10 = 1'b0;
  logic [9:0]  din10 = '0;
  logic        a10, b10, c10, y0_10, y1_10;
  logic        busy10, done10;
  logic [3:0]  count10;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign {y1_12, y0_12} = 2'(a12) + 2'(b12) + 2'(c12);
  assign {y1_10, y0_10} = 2'(a10) + 2'(b10) + 2'(c10);

  oc3_popcount_ctrl #(.W(12)) dut12 (
    .clk(clk), .rst(rst), .start(start12), .din(din12),
    .oc_a(a12), .oc_b(b12), .oc_c(c12),
    .oc_y0(y0_12), .oc_y1(y1_12),
    .busy(busy12), .done(done12), .count(count12)
  );

  oc3_popcount_ctrl #(.W(10)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .din(din10),
    .oc_a(a10), .oc_b(b10), .oc_c(c10),
    .oc_y0(y0_10), .oc_y1(y1_10),
    .busy(busy10), .done(done10), .count(count10)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One full W=12 operation with per-cycle checks against a popcount model.
  task automatic op12(input logic [11:0] d, output int got);
    int n;
    logic [11:0] m;
    @(negedge clk);
    din12   = d;
    start12 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    din12   = ~d;
    n = 0;
    while (busy12 && n < 20) begin
      m = 12'((1 << (3 * n)) - 1);
      chk("oc_abc", int'({a12, b12, c12}), int'((d >> (3 * n)) & 12'h7));
      chk("partial", int'(count12), $countones(d & m));
      chk("no_early_done", int'(done12), 0);
      n++;
      @(negedge clk);
    end
    chk("run_len", n, 4);
    chk("done_pulse", int'(done12), 1);
    chk("busy_in_done", int'(busy12), 0);
    chk("count", int'(count12), $countones(d));
    got = int'(count12);
    @(negedge clk);
    chk("done_low", int'(done12), 0);
    repeat (2) @(negedge clk);
    chk("count_hold", int'(count12), $countones(d));
  endtask

  typedef struct {
    logic [11:0] din;
    int          exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int got;
    int n;
    int dones;
    logic [11:0] r;

    tbl[0] = '{12'hFFF, 12};
    tbl[1] = '{12'hB19, 6};
    tbl[2] = '{12'h000, 0};
    tbl[3] = '{12'h001, 1};
    tbl[4] = '{12'h0F0, 4};
    tbl[5] = '{12'h800, 1};
    tbl[6] = '{12'h555, 6};

    // asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy12), 0);
    chk("rst_done", int'(done12), 0);
    chk("rst_count", int'(count12), 0);
    chk("rst_oc", int'({a12, b12, c12}), 0);
    chk("rst_count10", int'(count10), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      op12(tbl[i].din, got);
      chk("tbl_count", got, tbl[i].exp);
    end

    // start while busy and during done must be ignored
    @(negedge clk);
    din12   = 12'hB19;
    start12 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    @(negedge clk);
    din12   = 12'hFFF;
    start12 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    n = 0;
    while (!done12 && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("hs_done_seen", int'(done12), 1);
    start12 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    chk("hs_ignored_busy", int'(busy12), 0);
    chk("hs_count", int'(count12), 6);
    @(negedge clk);
    chk("hs_still_idle", int'(busy12), 0);
    op12(12'h001, got);
    chk("hs_next", got, 1);

    // reset mid-operation after the 2nd RUN edge
    @(negedge clk);
    din12   = 12'hFFF;
    start12 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_count", int'(count12), 6);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy12), 0);
    chk("mid_rst_count", int'(count12), 0);
    chk("mid_rst_done", int'(done12), 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done12) dones++;
    end
    chk("no_done_after_abort", dones, 0);
    op12(12'h0F0, got);
    chk("post_rst", got, 4);

    // padding: W=10 needs 4 groups, last one is 3'b001
    @(negedge clk);
    din10   = 10'h3FF;
    start10 = 1'b1;
    @(negedge clk);
    start10 = 1'b0;
    n = 0;
    while (busy10 && n < 20) begin
      if (n == 3) chk("w10_last_grp", int'({a10, b10, c10}), 1);
      n++;
      @(negedge clk);
    end
    chk("w10_run_len", n, 4);
    chk("w10_done", int'(done10), 1);
    chk("w10_count", int'(count10), 10);

    // random words against the popcount model
    repeat (30) begin
      r = 12'($urandom);
      op12(r, got);
      chk("rand_count", got, $countones(r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
